memory_macro_dp: RTL
====================

MEMORY_MACRO_DP -- requirements
Module: memory_macro_dp

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clka and rsta_n.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the address width, with DEPTH = 2^ADDR_WIDTH entries.
REQ-003 Parameter DATA_WIDTH, default 32, SHALL set the word width; it SHALL be a multiple of 8, with NBYTES = DATA_WIDTH/8.
REQ-004 Parameter INIT_VALUE, default 0, SHALL set the value written to every entry during the init sweep.
REQ-005 Parameter OUT_REG, default 0, SHALL add one output pipeline stage when set to 1.
REQ-006 clka  in  1  clock; all state changes on the rising edge.
REQ-007 rsta_n  in  1  asynchronous active-low reset.
REQ-008 init_done  out  1  high once the init sweep is complete and the ports are live.
REQ-009 wr_en  in  1  write request.
REQ-010 wr_addr  in  ADDR_WIDTH  write word address.
REQ-011 wr_be  in  NBYTES  per-byte write enable; bit i covers wr_data[8i+7:8i].
REQ-012 wr_data  in  DATA_WIDTH  write data.
REQ-013 rd_en  in  1  read request.
REQ-014 rd_addr  in  ADDR_WIDTH  read word address.
REQ-015 rd_data  out  DATA_WIDTH  read data.
REQ-016 rd_valid  out  1  rd_data is valid this cycle (1-cycle pulse per read).

Function
REQ-017 The init FSM SHALL have two states, INIT and READY; reset SHALL force INIT with the sweep counter at 0.
REQ-018 In INIT, the FSM SHALL write INIT_VALUE to entry counter each cycle and increment the counter; after entry DEPTH-1 it SHALL go to READY, so the sweep takes exactly DEPTH cycles.
REQ-019 init_done SHALL be 0 in INIT and 1 in READY; READY SHALL be left only by reset.
REQ-020 In INIT, wr_en and rd_en SHALL be ignored, and rd_valid SHALL stay 0.
REQ-021 In READY, a write with wr_en=1 SHALL update only the bytes whose wr_be bit is 1; wr_be=0 SHALL leave memory unchanged.
REQ-022 Read latency SHALL be 1+OUT_REG cycles from rd_en sampled high to rd_valid=1 with rd_data valid.
REQ-023 Back-to-back reads SHALL be accepted every cycle, at full throughput.
REQ-024 rd_data SHALL hold its last value when no read completes; it SHALL NOT be zeroed by rd_en=0.
REQ-025 A same-cycle write and read to different addresses SHALL both complete with no interaction.
REQ-026 A same-cycle write and read to the same address SHALL follow REQ-032/REQ-033.
REQ-027 Addresses SHALL wrap modulo DEPTH; no out-of-range state exists.

Reset
REQ-028 Asserting rsta_n low SHALL immediately clear rd_data to 0, rd_valid to 0, init_done to 0, the sweep counter to 0 and the pipeline valids to 0.
REQ-029 Reset in mid-sweep or mid-read SHALL drop any in-flight read, with no rd_valid pulse after release.
REQ-030 On rsta_n release, the FSM SHALL restart the full DEPTH-cycle sweep.
REQ-031 Memory contents SHALL NOT be cleared asynchronously; they are defined only after the sweep.

Configuration
REQ-032 With macro MEMORY_MACRO_DP_BYPASS_EN defined, a same-address same-cycle read SHALL return the old word with enabled bytes replaced by wr_data (write-first).
REQ-033 Without MEMORY_MACRO_DP_BYPASS_EN, a same-address same-cycle read SHALL return the pre-write word (read-first), and the forwarding logic SHALL be absent.

Verification
REQ-034 Reset, release, then rd_en at addr 3 on every cycle -> init_done rises exactly 16 cycles after release, no rd_valid before that, and the first read returns 0x00000000.
REQ-035 In READY, write addr 5 = 0xAABBCCDD with be=4'b1111, then write 0x11223344 with be=4'b0101, then read addr 5 -> 0xAA22CC44 after 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
REQ-036 Addr 7 = 0x12345678; write 0xFFFFFFFF with be=4'b0011 and read addr 7 in the same cycle -> 0x1234FFFF with BYPASS_EN, 0x12345678 without; a following read returns 0x1234FFFF in both builds.
REQ-037 Read addrs 0..15 on consecutive cycles after distinct writes -> 16 consecutive rd_valid pulses with data in address order.
REQ-038 Assert rsta_n low at sweep count 9, release -> outputs are 0 at once, the sweep restarts from 0, and init_done rises 16 cycles after release.
REQ-039 Write with be=4'b0000 to addr 2, then read addr 2 -> INIT_VALUE unchanged.

Source files
------------

// File: rtl/memory_macro_dp.sv
// ---------------------------------------------------------------------------
// memory_macro_dp
//   Simple dual-port (1 write, 1 read) word memory with per-byte write enables.
//   After reset, an init FSM sweeps INIT_VALUE into every entry, one entry per
//   cycle. Both ports are ignored until the sweep is complete. Reads return data
//   after 1 + OUT_REG cycles, and rd_data holds its value between reads.
//
//   Optional feature macro: MEMORY_MACRO_DP_BYPASS_EN
//     defined   : a same-address, same-cycle read sees the write (write-first).
//     undefined : the read returns the pre-write word (read-first), and no
//                 forwarding logic is built.
//
// Ports
//   clka      in   1           clock, rising edge
//   rsta_n    in   1           asynchronous active-low reset
//   init_done out  1           high once the init sweep is done
//   wr_en     in   1           write request
//   wr_addr   in   ADDR_WIDTH  write word address
//   wr_be     in   NBYTES      per-byte write enable (bit i -> byte i)
//   wr_data   in   DATA_WIDTH  write data
//   rd_en     in   1           read request
//   rd_addr   in   ADDR_WIDTH  read word address
//   rd_data   out  DATA_WIDTH  read data (held between reads)
//   rd_valid  out  1           one-cycle pulse per completed read
// ---------------------------------------------------------------------------
module memory_macro_dp #(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}},
    parameter int                    OUT_REG    = 0
) (
    input  logic                      clka,
    input  logic                      rsta_n,
    output logic                      init_done,
    input  logic                      wr_en,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH/8-1:0]   wr_be,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      rd_en,
    input  logic [ADDR_WIDTH-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid
);

    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam int                    NBYTES    = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Replace the bytes of old_word selected by be with the bytes of new_word.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NBYTES-1:0]     be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic                    init_done_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_word_d;
    logic                    rd_fire_s;
    logic                    s1_valid_q;
    logic [DATA_WIDTH-1:0]   s1_data_q;

    // Reads are accepted only once the sweep has finished.
    assign rd_fire_s = rd_en && (state_q == ST_READY);

    // Init FSM: sweep counter walks every entry once, then stays in READY until reset.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= {ADDR_WIDTH{1'b0}};
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + ADDR_ONE;
                    if (cnt_q == LAST_ADDR) begin
                        state_q     <= ST_READY;
                        init_done_q <= 1'b1;
                    end else begin
                        state_q     <= ST_INIT;
                        init_done_q <= 1'b0;
                    end
                end
                ST_READY: begin
                    state_q     <= ST_READY;
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_INIT;
                    cnt_q       <= {ADDR_WIDTH{1'b0}};
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: no reset, contents only defined once the sweep has run.
    always_ff @(posedge clka) begin
        if (state_q == ST_INIT) begin
            mem[cnt_q] <= INIT_VALUE;
        end else if (wr_en) begin
            mem[wr_addr] <= merge_bytes(mem[wr_addr], wr_data, wr_be);
        end
    end

    // Read word selection; the array write is non-blocking, so a plain read is read-first.
    always_comb begin
        rd_word_d = mem[rd_addr];
`ifdef MEMORY_MACRO_DP_BYPASS_EN
        if (wr_en && (state_q == ST_READY) && (wr_addr == rd_addr)) begin
            rd_word_d = merge_bytes(mem[rd_addr], wr_data, wr_be);
        end else begin
            rd_word_d = mem[rd_addr];
        end
`endif
    end

    // First read stage: data only updates on a read, so it holds between reads.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            s1_valid_q <= rd_fire_s;
            if (rd_fire_s) begin
                s1_data_q <= rd_word_d;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  out_valid_q;
            logic [DATA_WIDTH-1:0] out_data_q;

            // Optional output stage: captures only completing reads to keep the hold behaviour.
            always_ff @(posedge clka or negedge rsta_n) begin
                if (!rsta_n) begin
                    out_valid_q <= 1'b0;
                    out_data_q  <= {DATA_WIDTH{1'b0}};
                end else begin
                    out_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        out_data_q <= s1_data_q;
                    end
                end
            end

            assign rd_valid = out_valid_q;
            assign rd_data  = out_data_q;
        end else begin : g_no_out_reg
            assign rd_valid = s1_valid_q;
            assign rd_data  = s1_data_q;
        end
    endgenerate

    assign init_done = init_done_q;

endmodule
